sprite_register_sequencer: RTL

- Initiator side of the display-controller register-write bus.
- The CPU writes sprite attributes (indices BASE_INDEX..BASE_INDEX+NUM_REGS-1) into a local shadow table at any time. The block replays only the changed entries to the display controller at the start of each vertical blank, so sprites never tear mid-frame.
- Writes to indices outside that window pass through unchanged.
- Sits between the CPU peripheral bus and the display controller's register_write_i/register_index_i/register_write_value_i inputs.

---
 rtl/sprite_register_sequencer_pkg.sv | 20 ++
 rtl/sprite_register_sequencer_edge_detect.sv | 26 ++
 rtl/sprite_register_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sprite_register_sequencer_pkg.sv
// Shared constants for the sprite register sequencer: bus widths, the
// display-controller sprite register map and the flush FSM encoding.
package sprite_register_sequencer_pkg;

  localparam int unsigned IDX_W  = 7;
  localparam int unsigned DATA_W = 16;

  localparam logic [IDX_W-1:0] SPRITE0_X     = 7'd2;
  localparam logic [IDX_W-1:0] SPRITE0_Y     = 7'd3;
  localparam logic [IDX_W-1:0] SPRITE0_SHAPE = 7'd4;
  localparam logic [IDX_W-1:0] SPRITE0_EN    = 7'd5;
  localparam logic [IDX_W-1:0] SPRITE1_X     = 7'd6;
  localparam logic [IDX_W-1:0] SPRITE1_Y     = 7'd7;
  localparam logic [IDX_W-1:0] SPRITE1_SHAPE = 7'd8;
  localparam logic [IDX_W-1:0] SPRITE1_EN    = 7'd9;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

endpackage

// File: rtl/sprite_register_sequencer_edge_detect.sv
// Registered rising-edge detector; a level that is already high when reset
// is released does not count as an edge until it has been seen low.
module sprite_register_sequencer_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;
  logic primed_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      level_q  <= level_i;
      primed_q <= 1'b1;
    end
  end

  // level_q is only meaningful once a real sample has been taken.
  assign rise_o = level_i & ~level_q & primed_q;

endmodule

// File: rtl/sprite_register_sequencer.sv
// Shadows the sprite register window and replays dirty entries to the display
// controller at each vblank start; other CPU writes pass straight through.
module sprite_register_sequencer
  import sprite_register_sequencer_pkg::*;
#(
  parameter int unsigned BASE_INDEX = 2,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_write_i,
  input  logic [IDX_W-1:0]  cpu_index_i,
  input  logic [DATA_W-1:0] cpu_value_i,
  input  logic              in_vblank_i,
  output logic              register_write_o,
  output logic [IDX_W-1:0]  register_index_o,
  output logic [DATA_W-1:0] register_write_value_o,
  output logic              busy_o,
  output logic              flush_done_o,
  output logic [15:0]       frame_count_o
);

  localparam int unsigned     PTR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);

  logic [0:0]        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic              wr_q, wr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              done_q, done_d;
  logic [15:0]       fc_q, fc_d;

  logic [NUM_REGS-1:0] hit;
  logic                pass_through;
  logic                vblank_rise;

  sprite_register_sequencer_edge_detect u_vblank_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level_i (in_vblank_i),
    .rise_o  (vblank_rise)
  );

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      hit[i] = cpu_write_i && (cpu_index_i == IDX_W'(BASE_INDEX + i));
    end
  end

  assign pass_through = cpu_write_i & ~|hit;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    wr_d     = 1'b0;
    idx_d    = '0;
    val_d    = '0;
    done_d   = 1'b0;
    fc_d     = fc_q;

    if (vblank_rise) begin
      fc_d = fc_q + 16'd1;
    end

    if (pass_through) begin
      wr_d  = 1'b1;
      idx_d = cpu_index_i;
      val_d = cpu_value_i;
    end

    if (state_q == ST_IDLE) begin
      if (vblank_rise) begin
        state_d = ST_SCAN;
        ptr_d   = '0;
      end
    end else if (!pass_through) begin
      if (dirty_q[ptr_q]) begin
        wr_d           = 1'b1;
        idx_d          = IDX_W'(BASE_INDEX) + IDX_W'(ptr_q);
        val_d          = shadow_q[ptr_q];
        dirty_d[ptr_q] = 1'b0;
      end
      if (ptr_q == LAST_PTR) begin
        state_d = ST_IDLE;
        ptr_d   = '0;
        done_d  = 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end

    // Applied after the scan clear so a same-cycle CPU write re-marks the entry.
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (hit[i]) begin
        shadow_d[i] = cpu_value_i;
        dirty_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      dirty_q <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
      fc_q    <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      dirty_q  <= dirty_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
      done_q   <= done_d;
      fc_q     <= fc_d;
      shadow_q <= shadow_d;
    end
  end

  assign register_write_o       = wr_q;
  assign register_index_o       = idx_q;
  assign register_write_value_o = val_q;
  assign busy_o                 = (state_q == ST_SCAN);
  assign flush_done_o           = done_q;
  assign frame_count_o          = fc_q;

endmodule
